// File: rtl/wb_regfile_sb_pkg.sv
// Shared constants and types for the write-back register file and its scoreboard.
// Widths here match the WB result bus and the architectural register count.
package wb_regfile_sb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned ADDR_W = $clog2(NREGS);

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NREGS-1:0]  reg_vec_t;

  // One-hot decode of a register index into a per-register vector.
  function automatic reg_vec_t onehot(input reg_idx_t idx);
    reg_vec_t vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wb_regfile_sb_scoreboard.sv
// Pending-write scoreboard: tracks registers with a writer in flight and stalls
// decode on RAW/WAW hazards that the same-cycle write-back cannot resolve.
module wb_scoreboard
  import wb_regfile_sb_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              issue_vld,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [NREGS-1:0]  pending
);

  reg_vec_t pending_q, pending_d;
  reg_vec_t hz_vec;
  reg_vec_t set_vec, clr_vec;
  logic     issue_acc;

  // A register is a hazard only if pending and not being written back this cycle;
  // a same-cycle write-back is forwarded by the bypass in the top.
  always_comb begin
    hz_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      hz_vec[i] = pending_q[i] && !(wb_we && (wb_addr == reg_idx_t'(i)));
    end
  end

  always_comb begin
    stall = issue_vld && (hz_vec[rs1_addr] || hz_vec[rs2_addr] ||
                          (issue_we && hz_vec[issue_rd]));
    issue_acc = issue_vld && !stall;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_acc && issue_we) set_vec = onehot(issue_rd);
    if (wb_we)                 clr_vec = onehot(wb_addr);
    // Set wins over clear: a new writer is in flight after the old one retires.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    if (ZERO_REG) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

`ifndef SYNTHESIS
  stall_needs_issue: assert property (@(posedge clk) disable iff (!rst_n)
    stall |-> issue_vld);
  zero_never_pending: assert property (@(posedge clk) disable iff (!rst_n)
    ZERO_REG |-> !pending_q[0]);
`endif

endmodule

// File: rtl/wb_regfile_sb.sv
// Write-back register file: commits WB results, serves two bypassed read ports
// to decode, and hosts the pending-write scoreboard that stalls issue.
module wb_regfile_sb
  import wb_regfile_sb_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_vld,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [NREGS-1:0]  pending
);

  word_t regs_q [NREGS];
  logic  wb_commit;

  assign wb_commit = wb_we && !(ZERO_REG && (wb_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_commit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Zero register beats the bypass, which beats the stored value.
  function automatic word_t read_port(input reg_idx_t addr, input logic we,
                                      input reg_idx_t waddr, input word_t wdata,
                                      input word_t stored);
    if (ZERO_REG && (addr == '0)) return '0;
    if (we && (waddr == addr))    return wdata;
    return stored;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr, wb_we, wb_addr, wb_data, regs_q[rs1_addr]);
    rs2_data = read_port(rs2_addr, wb_we, wb_addr, wb_data, regs_q[rs2_addr]);
  end

  wb_scoreboard #(
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .issue_vld (issue_vld),
    .issue_we  (issue_we),
    .issue_rd  (issue_rd),
    .stall     (stall),
    .pending   (pending)
  );

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Self-checking bench for wb_regfile_sb: directed scenarios plus a randomized
// run against a reference model, with expectations queued at drive time.
module tb_wb_regfile_sb;
  import wb_regfile_sb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_we = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic [ADDR_W-1:0] rs1_addr = '0;
  logic [ADDR_W-1:0] rs2_addr = '0;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              issue_vld = 1'b0;
  logic              issue_we = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic              stall;
  logic [NREGS-1:0]  pending;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: expected read data, stall and pending vector.
  typedef struct packed {
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic              st;
    logic [NREGS-1:0]  pend;
  } exp_t;

  exp_t exp_q[$];

  wb_regfile_sb #(
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .issue_vld (issue_vld),
    .issue_we  (issue_we),
    .issue_rd  (issue_rd),
    .stall     (stall),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    issue_vld = 1'b0;
    issue_we  = 1'b0;
    issue_rd  = '0;
  endtask

  task automatic push(input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                      input logic st, input logic [NREGS-1:0] pend);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.st = st; e.pend = pend;
    exp_q.push_back(e);
  endtask

  // Pops one expectation and compares all four observed fields against it.
  task automatic pop_compare(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e.r1) begin
      errors++; $display("FAIL %s rs1_data: got %h expected %h", name, rs1_data, e.r1);
    end
    checks++;
    if (rs2_data !== e.r2) begin
      errors++; $display("FAIL %s rs2_data: got %h expected %h", name, rs2_data, e.r2);
    end
    checks++;
    if (stall !== e.st) begin
      errors++; $display("FAIL %s stall: got %b expected %b", name, stall, e.st);
    end
    checks++;
    if (pending !== e.pend) begin
      errors++; $display("FAIL %s pending: got %h expected %h", name, pending, e.pend);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd4; wb_data = 16'hCAFE;
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd6;
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    @(negedge clk); idle();
    rs1_addr = 4'd4; rs2_addr = 4'd6;
    push(16'hCAFE, 16'h0000, 1'b0, 16'h0040);
    #1 pop_compare("reset_pre");
    // Assert reset mid-cycle with a hazarding issue presented.
    issue_vld = 1'b1; rs2_addr = 4'd6;
    rst_n = 1'b0;
    push(16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1 pop_compare("reset_async");
    @(negedge clk); rst_n = 1'b1; idle();
    for (int i = 0; i < NREGS; i += 2) begin
      rs1_addr = ADDR_W'(i); rs2_addr = ADDR_W'(i + 1);
      push(16'h0000, 16'h0000, 1'b0, 16'h0000);
      #1 pop_compare($sformatf("reset_read_r%0d", i));
    end
  endtask

  task automatic test_write_read();
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF; rs1_addr = 4'd0; rs2_addr = 4'd0;
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd15; wb_data = 16'h5A5A;
    @(negedge clk); idle();
    rs1_addr = 4'd3; rs2_addr = 4'd15;
    push(16'hBEEF, 16'h5A5A, 1'b0, 16'h0000);
    #1 pop_compare("write_read");
  endtask

  task automatic test_bypass();
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 16'h1234; rs1_addr = 4'd3; rs2_addr = 4'd5;
    push(16'hBEEF, 16'h1234, 1'b0, 16'h0000);
    #1 pop_compare("bypass_same_cycle");
    @(negedge clk); idle();
    push(16'hBEEF, 16'h1234, 1'b0, 16'h0000);
    #1 pop_compare("bypass_stored");
  endtask

  task automatic test_raw();
    @(negedge clk); idle();
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd7;
    push(16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1 pop_compare("raw_issue");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle();
      issue_vld = 1'b1; rs1_addr = 4'd7;
      push(16'h0000, 16'h0000, 1'b1, 16'h0080);
      #1 pop_compare($sformatf("raw_stall_%0d", c));
    end
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 4'd7; wb_data = 16'h7777;
    push(16'h7777, 16'h0000, 1'b0, 16'h0080);
    #1 pop_compare("raw_wb_cycle");
    @(negedge clk); idle();
    push(16'h7777, 16'h0000, 1'b0, 16'h0000);
    #1 pop_compare("raw_cleared");
  endtask

  task automatic test_collision();
    @(negedge clk); idle();
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd7;
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd7; wb_data = 16'hA5A5;
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd7;
    push(16'h0000, 16'h0000, 1'b0, 16'h0080);
    #1 pop_compare("collision_cycle");
    @(negedge clk); idle();
    rs1_addr = 4'd7;
    push(16'hA5A5, 16'h0000, 1'b0, 16'h0080);
    #1 pop_compare("collision_after");
    wb_we = 1'b1; wb_addr = 4'd7; wb_data = 16'h0707;
    @(negedge clk); idle();
    push(16'h0707, 16'h0000, 1'b0, 16'h0000);
    #1 pop_compare("collision_drain");
  endtask

  task automatic test_waw();
    @(negedge clk); idle();
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd9;
    @(negedge clk);
    push(16'h0000, 16'h0000, 1'b1, 16'h0200);
    #1 pop_compare("waw_stall");
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 4'd9; wb_data = 16'h0909;
    push(16'h0000, 16'h0000, 1'b0, 16'h0200);
    #1 pop_compare("waw_resolved");
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd9; wb_data = 16'h9999;
    @(negedge clk); idle();
    wb_we = 1'b1; wb_addr = 4'd10; wb_data = 16'h1010;
    @(negedge clk); idle();
    rs1_addr = 4'd9; rs2_addr = 4'd10;
    push(16'h9999, 16'h1010, 1'b0, 16'h0000);
    #1 pop_compare("wb_not_pending");
  endtask

  task automatic test_zero_reg();
    @(negedge clk); idle();
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd0;
    push(16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1 pop_compare("zero_wb_cycle");
    @(negedge clk); idle();
    issue_vld = 1'b1; issue_we = 1'b1; issue_rd = 4'd0;
    push(16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1 pop_compare("zero_after");
  endtask

  // Randomized traffic on a narrow register window to provoke hazards.
  task automatic test_random();
    word_t             mdl [NREGS];
    logic [NREGS-1:0]  mpend;
    logic [DATA_W-1:0] e1, e2;
    logic              est, hz1, hz2, hzd;
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    mpend = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      wb_we     = ($urandom_range(0, 2) != 0);
      wb_addr   = ADDR_W'($urandom_range(0, 7));
      wb_data   = DATA_W'($urandom);
      rs1_addr  = ADDR_W'($urandom_range(0, 7));
      rs2_addr  = ADDR_W'($urandom_range(0, 7));
      issue_vld = ($urandom_range(0, 3) != 0);
      issue_we  = ($urandom_range(0, 1) != 0);
      issue_rd  = ADDR_W'($urandom_range(0, 7));
      e1 = (rs1_addr == 0) ? '0 : (wb_we && wb_addr == rs1_addr) ? wb_data : mdl[rs1_addr];
      e2 = (rs2_addr == 0) ? '0 : (wb_we && wb_addr == rs2_addr) ? wb_data : mdl[rs2_addr];
      hz1 = mpend[rs1_addr] && !(wb_we && wb_addr == rs1_addr);
      hz2 = mpend[rs2_addr] && !(wb_we && wb_addr == rs2_addr);
      hzd = mpend[issue_rd] && !(wb_we && wb_addr == issue_rd);
      est = issue_vld && (hz1 || hz2 || (issue_we && hzd));
      push(e1, e2, est, mpend);
      #1 pop_compare($sformatf("random_%0d", c));
      if (wb_we && wb_addr != 0) mdl[wb_addr] = wb_data;
      if (wb_we) mpend[wb_addr] = 1'b0;
      if (issue_vld && !est && issue_we && issue_rd != 0) mpend[issue_rd] = 1'b1;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_raw();
    test_collision();
    test_waw();
    test_zero_reg();
    test_random();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
